bus_mem_ctrl: RTL

- Slave memory controller on the 8088 minimum-mode multiplexed bus; sits directly downstream of processor_8088.
- Demultiplexes the address on ALE and decodes a memory window.
- Services read/write strobes from an internal byte RAM, inserting programmable wait states via READY.
- Replaces the behavioural test memory in processor-level simulation and synthesis.

---
 rtl/bus_pkg.sv | 17 +
 rtl/bus_ram.sv | 23 ++
 rtl/bus_mem_ctrl.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/bus_pkg.sv
// Shared definitions for the 8088 minimum-mode memory slave: bus widths,
// wait-counter width and the controller state encoding.
package bus_pkg;

    localparam int CPU_ADDR_W = 20;
    localparam int DATA_W     = 8;
    localparam int WAIT_CNT_W = 4;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE    = 3'd0;
    localparam state_t S_ADDR    = 3'd1;
    localparam state_t S_WAIT    = 3'd2;
    localparam state_t S_RD_DATA = 3'd3;
    localparam state_t S_WR_DATA = 3'd4;

endpackage

// File: rtl/bus_ram.sv
// Single-port synchronous byte RAM with registered read; contents are never reset.
module bus_ram
    import bus_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
        rdata_o <= mem_q[addr_i];
    end

endmodule

// File: rtl/bus_mem_ctrl.sv
// 8088 bus slave: latches the address on ALE, decodes the window and serves
// strobes from bus_ram with WAIT_STATES of READY-low. Option: ROM_PROTECT_EN.
//
// state     | meaning
// S_IDLE    | no cycle in progress
// S_ADDR    | address latched, waiting for a strobe
// S_WAIT    | strobe accepted, ready held low
// S_RD_DATA | driving read data until rd_n rises
// S_WR_DATA | byte committed, waiting for wr_n to rise
module bus_mem_ctrl
    import bus_pkg::*;
#(
    parameter int                    ADDR_W      = 10,
    parameter logic [CPU_ADDR_W-1:0] BASE_ADDR   = 20'h00000,
    parameter int                    WAIT_STATES = 1,
    parameter logic [ADDR_W-1:0]     ROM_START   = ADDR_W'('h300)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ale,
    input  logic              rd_n,
    input  logic              wr_n,
    input  logic              iom,
    input  logic [11:0]       a,
    input  logic [7:0]        ad_in,
    output logic [DATA_W-1:0] ad_out,
    output logic              ad_oe,
    output logic              ready,
    output logic              sel,
    output logic              write_done,
    output logic              wr_err
);

`ifdef ROM_PROTECT_EN
    localparam bit ROM_PROT = 1'b1;
`else
    localparam bit ROM_PROT = 1'b0;
`endif

    localparam logic [WAIT_CNT_W-1:0] WS_CNT  = WAIT_CNT_W'(WAIT_STATES);
    localparam logic [WAIT_CNT_W-1:0] CNT_ONE = WAIT_CNT_W'(1);

    state_t                  state_q;
    logic [ADDR_W-1:0]       addr_q;
    logic                    sel_q, is_rd_q, ready_q, ad_oe_q, write_done_q, wr_err_q;
    logic [WAIT_CNT_W-1:0]   cnt_q;
    logic [CPU_ADDR_W-1:0]   ale_addr;
    logic [DATA_W-1:0]       ram_rdata;
    logic                    strobe_any, strobe_held, enter_wr, rom_hit, ram_we;

    assign ale_addr    = {a, ad_in};
    assign strobe_any  = !rd_n || !wr_n;
    assign strobe_held = is_rd_q ? !rd_n : !wr_n;
    assign rom_hit     = ROM_PROT && (addr_q >= ROM_START);

    // The byte is committed on the edge that enters S_WR_DATA, using ad_in sampled there.
    assign enter_wr = !ale &&
                      (((state_q == S_ADDR) && sel_q && rd_n && !wr_n && (WS_CNT == '0)) ||
                       ((state_q == S_WAIT) && !is_rd_q && !wr_n && (cnt_q == CNT_ONE)));
    assign ram_we   = enter_wr && !rom_hit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            sel_q        <= 1'b0;
            is_rd_q      <= 1'b0;
            ready_q      <= 1'b1;
            ad_oe_q      <= 1'b0;
            write_done_q <= 1'b0;
            wr_err_q     <= 1'b0;
            cnt_q        <= '0;
        end else begin
            write_done_q <= ram_we;
            wr_err_q     <= enter_wr && rom_hit;
            if (ale) begin
                addr_q  <= ale_addr[ADDR_W-1:0];
                sel_q   <= !iom && (ale_addr[CPU_ADDR_W-1:ADDR_W] == BASE_ADDR[CPU_ADDR_W-1:ADDR_W]);
                state_q <= S_ADDR;
                ready_q <= 1'b1;
                ad_oe_q <= 1'b0;
                cnt_q   <= '0;
            end else begin
                case (state_q)
                    S_ADDR: begin
                        if (sel_q && strobe_any) begin
                            is_rd_q <= !rd_n;
                            cnt_q   <= WS_CNT;
                            if (WS_CNT != '0) begin
                                state_q <= S_WAIT;
                                ready_q <= 1'b0;
                            end else if (!rd_n) begin
                                state_q <= S_RD_DATA;
                                ad_oe_q <= 1'b1;
                            end else begin
                                state_q <= S_WR_DATA;
                            end
                        end
                    end
                    S_WAIT: begin
                        if (!strobe_held) begin
                            state_q <= S_IDLE;
                            ready_q <= 1'b1;
                            cnt_q   <= '0;
                        end else if (cnt_q == CNT_ONE) begin
                            ready_q <= 1'b1;
                            cnt_q   <= '0;
                            state_q <= is_rd_q ? S_RD_DATA : S_WR_DATA;
                            ad_oe_q <= is_rd_q;
                        end else begin
                            cnt_q <= cnt_q - CNT_ONE;
                        end
                    end
                    S_RD_DATA: begin
                        if (rd_n) begin
                            state_q <= S_IDLE;
                            ad_oe_q <= 1'b0;
                        end
                    end
                    S_WR_DATA: begin
                        if (wr_n) begin
                            state_q <= S_IDLE;
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    bus_ram #(.ADDR_W(ADDR_W)) u_ram (
        .clk     (clk),
        .we_i    (ram_we),
        .addr_i  (addr_q),
        .wdata_i (ad_in),
        .rdata_o (ram_rdata)
    );

    assign ad_out     = ad_oe_q ? ram_rdata : '0;
    assign ad_oe      = ad_oe_q;
    assign ready      = ready_q;
    assign sel        = sel_q;
    assign write_done = write_done_q;
    assign wr_err     = wr_err_q;

endmodule
